ta_adc_acq_ctrl: RTL and testbench



---
 rtl/ta_adc_pkg.sv | 28 ++
 rtl/ta_adc_trig_det.sv | 56 +++++
 rtl/ta_adc_acq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ta_adc_acq_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ta_adc_pkg.sv
// Shared definitions for the 250 MS/s ADC acquisition sequencer: state and
// trigger-mode encodings, default sample width and the arm config check.
package ta_adc_pkg;

  localparam int ADC_DATA_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } acq_state_e;

  typedef enum logic [1:0] {
    TRIG_SOFT = 2'd0,
    TRIG_EXT  = 2'd1,
    TRIG_RISE = 2'd2,
    TRIG_FALL = 2'd3
  } trig_mode_e;

  // Pre samples, trigger sample and post samples must all fit in the ring.
  function automatic logic cfg_fits(input int unsigned pre, input int unsigned post,
                                    input int unsigned addr_w);
    return (pre + post + 32'd1) <= (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/ta_adc_trig_det.sv
// Trigger detector: ext_trig synchronizer with edge detect, previous-sample
// register and threshold crossing compare; trig_hit is aligned to adc_data.
module ta_adc_trig_det
  import ta_adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
) (
  input  logic              clk250,
  input  logic              rst,
  input  logic              ext_trig,
  input  logic              soft_trig,
  input  logic [1:0]        trig_mode,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [DATA_W-1:0] adc_data,
  output logic              trig_hit
);

  logic [1:0]        ext_sync_q, ext_sync_d;
  logic              ext_dly_q, ext_dly_d;
  logic              ext_edge_q, ext_edge_d;
  logic [DATA_W-1:0] prev_q, prev_d;

  // Edge is registered so a pin rise is seen three cycles later.
  always_comb begin
    ext_sync_d = {ext_sync_q[0], ext_trig};
    ext_dly_d  = ext_sync_q[1];
    ext_edge_d = ext_sync_q[1] & ~ext_dly_q;
    prev_d     = adc_data;
  end

  always_ff @(posedge clk250) begin
    if (rst) begin
      ext_sync_q <= '0;
      ext_dly_q  <= 1'b0;
      ext_edge_q <= 1'b0;
      prev_q     <= '0;
    end else begin
      ext_sync_q <= ext_sync_d;
      ext_dly_q  <= ext_dly_d;
      ext_edge_q <= ext_edge_d;
      prev_q     <= prev_d;
    end
  end

  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode)
      TRIG_SOFT: trig_hit = soft_trig;
      TRIG_EXT:  trig_hit = ext_edge_q;
      TRIG_RISE: trig_hit = (prev_q < trig_level) && (adc_data >= trig_level);
      TRIG_FALL: trig_hit = (prev_q >= trig_level) && (adc_data < trig_level);
      default:   trig_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ta_adc_acq_ctrl.sv
// Acquisition sequencer: arm, pre-trigger fill, wait for trigger and
// post-trigger capture into an external ring-buffer RAM.
module ta_adc_acq_ctrl
  import ta_adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int ADDR_W = 12
) (
  input  logic              clk250,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              soft_trig,
  input  logic              ext_trig,
  input  logic [1:0]        trig_mode,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W-1:0] post_len,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_of,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W:0]   wr_data,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              of_seen,
  output logic [2:0]        state_o
);

  acq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] post_len_q, post_len_d;
  logic [DATA_W:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0] level_q, level_d;
  logic [1:0]        mode_q, mode_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;
  logic              of_seen_q, of_seen_d;
  logic              busy_now, write_now, cfg_ok, trig_hit;

  ta_adc_trig_det #(.DATA_W(DATA_W)) u_trig_det (
    .clk250     (clk250),
    .rst        (rst),
    .ext_trig   (ext_trig),
    .soft_trig  (soft_trig),
    .trig_mode  (mode_q),
    .trig_level (level_q),
    .adc_data   (adc_data),
    .trig_hit   (trig_hit)
  );

  assign busy_now  = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
  assign write_now = busy_now && !abort;
  assign cfg_ok    = cfg_fits(32'(pre_len), 32'(post_len), ADDR_W);

  // Samples taken while busy are written one cycle later; abort wins over
  // everything, including an arm or trigger in the same cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    trig_addr_d = trig_addr_q;
    post_len_d  = post_len_q;
    level_d     = level_q;
    mode_d      = mode_q;
    done_d      = done_q;
    cfg_err_d   = cfg_err_q;
    of_seen_d   = of_seen_q;
    wr_en_d     = write_now;

    if (write_now) begin
      wr_addr_d = wr_ptr_q;
      wr_data_d = {adc_of, adc_data};
      wr_ptr_d  = wr_ptr_q + 1'b1;
      of_seen_d = of_seen_q | adc_of;
    end

    if (abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            if (cfg_ok) begin
              cfg_err_d  = 1'b0;
              done_d     = 1'b0;
              of_seen_d  = 1'b0;
              wr_ptr_d   = '0;
              cnt_d      = pre_len;
              post_len_d = post_len;
              level_d    = trig_level;
              mode_d     = trig_mode;
              state_d    = (pre_len == '0) ? ST_WAIT : ST_PRE;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        ST_PRE: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == ADDR_W'(1)) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (trig_hit) begin
            trig_addr_d = wr_ptr_q;
            cnt_d       = post_len_q;
            if (post_len_q == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end
        end
        ST_POST: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == ADDR_W'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk250) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      trig_addr_q <= '0;
      post_len_q  <= '0;
      level_q     <= '0;
      mode_q      <= '0;
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      of_seen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      trig_addr_q <= trig_addr_d;
      post_len_q  <= post_len_d;
      level_q     <= level_d;
      mode_q      <= mode_d;
      wr_en_q     <= wr_en_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      of_seen_q   <= of_seen_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign trig_addr = trig_addr_q;
  assign busy      = busy_now;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign of_seen   = of_seen_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_ta_adc_acq_ctrl.sv
// Scoreboard bench for ta_adc_acq_ctrl: each acquisition's RAM writes are
// predicted from the stimulus tables and popped by a write monitor.
module tb_ta_adc_acq_ctrl;
  import ta_adc_pkg::*;

  localparam int DW      = 14;
  localparam int AW      = 4;
  localparam int LEN     = 64;
  localparam int NO_TRIG = 1 << 20;

  logic          clk250 = 1'b0;
  logic          rst, arm, abort, soft_trig, ext_trig, adc_of;
  logic [1:0]    trig_mode;
  logic [DW-1:0] trig_level, adc_data;
  logic [AW-1:0] pre_len, post_len;
  logic          wr_en, busy, done, cfg_err, of_seen;
  logic [AW-1:0] wr_addr, trig_addr;
  logic [DW:0]   wr_data;
  logic [2:0]    state_o;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW:0]   data;
    bit            is_trig;
  } exp_wr_t;

  exp_wr_t exp_q[$];
  exp_wr_t mon_item;
  int      tests_run = 0;
  int      tests_failed = 0;

  int data_arr[LEN+1];
  bit of_arr[LEN+1];
  bit soft_arr[LEN+1];
  bit ext_arr[LEN+1];
  bit arm_arr[LEN+1];
  bit abort_arr[LEN+1];

  ta_adc_acq_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk250(clk250), .rst(rst), .arm(arm), .abort(abort), .soft_trig(soft_trig),
    .ext_trig(ext_trig), .trig_mode(trig_mode), .trig_level(trig_level),
    .pre_len(pre_len), .post_len(post_len), .adc_data(adc_data), .adc_of(adc_of),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .trig_addr(trig_addr),
    .busy(busy), .done(done), .cfg_err(cfg_err), .of_seen(of_seen), .state_o(state_o)
  );

  always #5 clk250 = ~clk250;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Every RAM write must match the next predicted word, in order.
  always @(negedge clk250) begin
    if (wr_en === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_write actual addr=%0d data=0x%0h required no write",
                 wr_addr, wr_data);
      end else begin
        mon_item = exp_q.pop_front();
        if (wr_addr !== mon_item.addr || wr_data !== mon_item.data) begin
          tests_failed++;
          $display("[TB] FAIL ram_write actual addr=%0d data=0x%0h required addr=%0d data=0x%0h",
                   wr_addr, wr_data, mon_item.addr, mon_item.data);
        end
        if (mon_item.is_trig) checkOutput("trig_addr", 32'(trig_addr), 32'(mon_item.addr));
      end
    end
  end

  task automatic clearStim();
    for (int i = 0; i <= LEN; i++) begin
      data_arr[i] = 0; of_arr[i] = 0; soft_arr[i] = 0;
      ext_arr[i] = 0; arm_arr[i] = 0; abort_arr[i] = 0;
    end
    arm_arr[0] = 1;
    abort_arr[LEN] = 1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk250); #2;
      rst = 0; arm = 0; abort = 0; soft_trig = 0; ext_trig = 0; adc_of = 0;
      adc_data = DW'($urandom);
    end
  endtask

  // Index of the trigger sample (cycle after arm), straight from the trigger rules.
  function automatic int find_trig(input int mode, input int level, input int pre);
    for (int i = pre + 1; i <= LEN; i++) begin
      bit hit;
      hit = 0;
      case (mode)
        0: hit = soft_arr[i];
        1: if (i >= 3) hit = ext_arr[i-3] && ((i == 3) || !ext_arr[(i >= 4) ? i-4 : 0]);
        2: hit = (data_arr[i-1] < level) && (data_arr[i] >= level);
        default: hit = (data_arr[i-1] >= level) && (data_arr[i] < level);
      endcase
      if (hit) return i;
    end
    return NO_TRIG;
  endfunction

  task automatic applyStimulus(input int mode, input int level, input int pre, input int post,
                               input int rst_idx);
    int a, t, last_w, st;
    bit of_e;
    exp_wr_t item;
    a = LEN;
    for (int i = LEN; i >= 0; i--) if (abort_arr[i]) a = i;
    if (rst_idx > 0 && rst_idx < a) a = rst_idx;
    t = find_trig(mode, level, pre);
    if (t >= a) t = NO_TRIG;
    last_w = (t != NO_TRIG && t + post < a) ? t + post : a - 1;
    for (int j = 1; j <= last_w; j++) begin
      item.addr    = AW'(j - 1);
      item.data    = {of_arr[j], DW'(data_arr[j])};
      item.is_trig = (j == t);
      exp_q.push_back(item);
    end
    for (int i = 0; i <= LEN; i++) begin
      @(posedge clk250); #2;
      rst = (rst_idx > 0 && i == rst_idx);
      arm = arm_arr[i]; abort = abort_arr[i]; soft_trig = soft_arr[i]; ext_trig = ext_arr[i];
      adc_data = DW'(data_arr[i]); adc_of = of_arr[i]; trig_mode = 2'(mode);
      if (i == 0) begin
        trig_level = DW'(level); pre_len = AW'(pre); post_len = AW'(post);
      end else begin
        trig_level = DW'($urandom); pre_len = AW'($urandom); post_len = AW'($urandom);
      end
      @(negedge clk250);
      if (rst_idx > 0 && i > rst_idx) begin
        if (i == rst_idx + 1)
          checkOutput("reset_mid_capture",
                      {1'b0, wr_en, wr_addr, wr_data, trig_addr, busy, done, cfg_err, of_seen, state_o},
                      32'd0);
      end else if (i >= 1) begin
        if (i > a) st = 0;
        else if (i <= pre) st = 1;
        else if (i <= t) st = 2;
        else if (i <= t + post) st = 3;
        else st = 4;
        of_e = 0;
        for (int j = 1; j <= last_w && j <= i - 1; j++) of_e |= of_arr[j];
        checkOutput("status", {25'd0, state_o, busy, done, cfg_err, of_seen},
                    {25'd0, 3'(st), (st >= 1 && st <= 3), (st == 4), 1'b0, of_e});
      end
    end
    idleCycles(5);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic checkCfgReject();
    @(posedge clk250); #2;
    arm = 1; pre_len = AW'(10); post_len = AW'(6);
    @(posedge clk250); #2;
    arm = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk250);
      checkOutput("cfg_reject", {28'd0, state_o, cfg_err}, {28'd0, 3'd0, 1'b1});
      checkOutput("cfg_reject_busy", {30'd0, busy, done}, 32'd0);
      @(posedge clk250); #2;
    end
  endtask

  initial begin
    rst = 1; arm = 0; abort = 0; soft_trig = 0; ext_trig = 0; adc_of = 0;
    trig_mode = 0; trig_level = 0; adc_data = 0; pre_len = 0; post_len = 0;
    repeat (3) @(posedge clk250);
    @(negedge clk250);
    checkOutput("reset_values",
                {1'b0, wr_en, wr_addr, wr_data, trig_addr, busy, done, cfg_err, of_seen, state_o}, 32'd0);
    @(posedge clk250); #2;
    rst = 0;
    idleCycles(3);

    // Ramp with a soft trigger on the sample valued 10.
    clearStim();
    for (int i = 0; i <= LEN; i++) data_arr[i] = i;
    soft_arr[10] = 1;
    soft_arr[2]  = 1;
    applyStimulus(0, 0, 3, 4, 0);

    // Rising and falling threshold crossings on the same waveform.
    for (int m = 2; m <= 3; m++) begin
      clearStim();
      data_arr[0] = 120; data_arr[1] = 120; data_arr[2] = 120;
      data_arr[3] = 100; data_arr[4] = 100; data_arr[5] = 101; data_arr[6] = 99;
      data_arr[7] = 90;  data_arr[8] = 95;  data_arr[9] = 99;  data_arr[10] = 100;
      for (int i = 11; i <= LEN; i++) data_arr[i] = 101;
      applyStimulus(m, 100, 2, 3, 0);
    end

    // Long wait wraps the ring before the trigger and during post.
    clearStim();
    for (int i = 0; i <= LEN; i++) data_arr[i] = $urandom_range(0, 16383);
    soft_arr[45] = 1;
    applyStimulus(0, 0, 2, 5, 0);

    checkCfgReject();
    clearStim();
    for (int i = 0; i <= LEN; i++) data_arr[i] = $urandom_range(0, 16383);
    soft_arr[20] = 1;
    applyStimulus(0, 0, 9, 6, 0);

    // Abort coincident with the trigger.
    clearStim();
    for (int i = 0; i <= LEN; i++) data_arr[i] = $urandom_range(0, 16383);
    soft_arr[8] = 1; abort_arr[8] = 1;
    applyStimulus(0, 0, 3, 4, 0);

    // Re-arm during post-trigger capture has no effect.
    clearStim();
    for (int i = 0; i <= LEN; i++) data_arr[i] = $urandom_range(0, 16383);
    soft_arr[5] = 1; arm_arr[8] = 1;
    applyStimulus(0, 0, 1, 6, 0);

    // External trigger plus an overflow in the pre-trigger window.
    clearStim();
    for (int i = 0; i <= LEN; i++) data_arr[i] = $urandom_range(0, 16383);
    for (int i = 6; i <= 10; i++) ext_arr[i] = 1;
    soft_arr[4] = 1; of_arr[1] = 1;
    applyStimulus(1, 0, 2, 3, 0);

    // Zero pre and post lengths.
    clearStim();
    for (int i = 0; i <= LEN; i++) data_arr[i] = i;
    applyStimulus(2, 5, 0, 0, 0);

    // Reset in the middle of post-trigger capture.
    clearStim();
    for (int i = 0; i <= LEN; i++) data_arr[i] = $urandom_range(0, 16383);
    soft_arr[10] = 1; of_arr[4] = 1;
    applyStimulus(0, 0, 3, 4, 12);

    for (int r = 0; r < 8; r++) begin
      int mode, pre, post;
      bit ext_lvl;
      clearStim();
      mode = $urandom_range(0, 3);
      pre  = $urandom_range(0, 10);
      post = $urandom_range(0, 15 - pre);
      ext_lvl = 0;
      for (int i = 0; i <= LEN; i++) begin
        data_arr[i] = $urandom_range(0, 1023);
        soft_arr[i] = ($urandom_range(0, 15) == 0);
        of_arr[i]   = ($urandom_range(0, 19) == 0);
        if (i > 0 && $urandom_range(0, 7) == 0) ext_lvl = ~ext_lvl;
        ext_arr[i]  = ext_lvl;
        if (i > 0 && i < LEN && $urandom_range(0, 99) == 0) abort_arr[i] = 1;
      end
      applyStimulus(mode, $urandom_range(0, 1023), pre, post, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
